// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad: drives one row low at a time,
//   samples the (synchronized) columns at the end of each row dwell, and
//   turns each debounced press into a registered key code plus a one-cycle
//   valid pulse. Held keys never repeat; a debounced release is required
//   before the next key can be accepted.
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   col_in     keypad columns, active-low, externally pulled up
//   row_out    keypad rows, active-low, exactly one bit low
//   key_code   last accepted key, row*4 + col
//   key_valid  one-cycle pulse on acceptance
//   key_held   high from acceptance until the release is accepted
module keypad_scanner #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned STABLE_SCANS = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam int unsigned SW = $clog2(STABLE_SCANS + 1);

   localparam logic [1:0] ST_SCAN     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_HELD     = 2'd2;

   logic [3:0]    sync1;
   logic [3:0]    col_s;
   logic [CW-1:0] cnt;
   logic [1:0]    row_idx;
   logic [1:0]    state;
   logic [1:0]    cand_col;
   logic [1:0]    hit_col;
   logic [SW-1:0] run_cnt;
   logic [31:0]   run_ext;
   logic          sample;
   logic          single;
   logic          last_run;

   assign sample  = (cnt == CW'(SCAN_DIV - 1));
   assign row_out = ~(4'b0001 << row_idx);

   // Exactly one column low -> a single key on the driven row.
   always_comb begin
      single  = 1'b1;
      hit_col = 2'd0;
      unique case (col_s)
         4'b1110: hit_col = 2'd0;
         4'b1101: hit_col = 2'd1;
         4'b1011: hit_col = 2'd2;
         4'b0111: hit_col = 2'd3;
         default: single  = 1'b0;
      endcase
   end

   // The count is tested before incrementing so it never has to hold
   // STABLE_SCANS itself beyond its sized width.
   assign run_ext  = {{(32 - SW){1'b0}}, run_cnt};
   assign last_run = (run_ext >= STABLE_SCANS - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= '1;
         col_s     <= '1;
         cnt       <= '0;
         row_idx   <= '0;
         state     <= ST_SCAN;
         cand_col  <= '0;
         run_cnt   <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         sync1     <= col_in;
         col_s     <= sync1;
         key_valid <= 1'b0;
         cnt       <= sample ? '0 : cnt + 1'b1;
         if (sample) begin
            case (state)
               ST_SCAN: begin
                  if (single) begin
                     cand_col <= hit_col;
                     run_cnt  <= SW'(1);
                     state    <= ST_DEBOUNCE;
                  end else begin
                     row_idx <= row_idx + 1'b1;
                  end
               end
               ST_DEBOUNCE: begin
                  if (single && hit_col == cand_col) begin
                     if (last_run) begin
                        key_code  <= {row_idx, cand_col};
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        run_cnt   <= '0;
                        state     <= ST_HELD;
                     end else begin
                        run_cnt <= run_cnt + 1'b1;
                     end
                  end else begin
                     state   <= ST_SCAN;
                     row_idx <= row_idx + 1'b1;
                  end
               end
               ST_HELD: begin
                  if (col_s == 4'hF) begin
                     if (last_run) begin
                        key_held <= 1'b0;
                        state    <= ST_SCAN;
                        row_idx  <= row_idx + 1'b1;
                     end else begin
                        run_cnt <= run_cnt + 1'b1;
                     end
                  end else begin
                     run_cnt <= '0;
                  end
               end
               default: state <= ST_SCAN;
            endcase
         end
      end
   end

endmodule
